// File: rtl/ganador_banner_ctrl.sv
// Winner banner animation: slide down to a centred target, blink, then hold until clear.
// Macro BANNER_SLIDE_EN enables the slide phase; without it a win goes straight to BLINK.
module ganador_banner_ctrl #(
  parameter int unsigned SCREEN_H     = 480,
  parameter int unsigned SPR_H        = 16,
  parameter int unsigned TARGET_X     = 275,
  parameter int unsigned START_Y      = 0,
  parameter int unsigned TARGET_Y     = 232,
  parameter int unsigned STEP         = 8,
  parameter int unsigned BLINK_FRAMES = 15,
  parameter int unsigned BLINK_COUNT  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] posx,
  input  logic [9:0] posy,
  input  logic       win,
  input  logic       clear,
  output logic [9:0] pixelx,
  output logic [9:0] pixely,
  output logic       gano,
  output logic [1:0] state
);

  // Keep the whole sprite on screen even if the target is misconfigured.
  localparam int unsigned TY_C = (TARGET_Y + SPR_H > SCREEN_H) ? (SCREEN_H - SPR_H) : TARGET_Y;
  localparam int unsigned FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int unsigned TG_W = (BLINK_COUNT > 0) ? $clog2(2 * BLINK_COUNT + 1) : 1;

  localparam logic [9:0]      TX_10   = 10'(TARGET_X);
  localparam logic [9:0]      SY_10   = 10'(START_Y);
  localparam logic [9:0]      TY_10   = 10'(TY_C);
  localparam logic [9:0]      SH_10   = 10'(SCREEN_H);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);
  localparam logic [TG_W-1:0] TG_LAST = TG_W'(2 * BLINK_COUNT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SLIDE = 2'd1,
    ST_BLINK = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [9:0]      pixely_q, pixely_d;
  logic            gano_q, gano_d;
  logic [FC_W-1:0] frame_q, frame_d;
  logic [TG_W-1:0] tog_q, tog_d;
  logic            vb, vb_q, tick;

  assign vb   = (posx == '0) && (posy == SH_10);
  assign tick = vb & ~vb_q;

`ifdef BANNER_SLIDE_EN
  localparam logic [10:0] STEP_11 = 11'(STEP);
  localparam logic [10:0] TY_11   = 11'(TY_C);
  logic [10:0] slide_sum;
  assign slide_sum = {1'b0, pixely_q} + STEP_11;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      pixely_q <= SY_10;
      gano_q   <= 1'b0;
      frame_q  <= '0;
      tog_q    <= '0;
      vb_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      pixely_q <= pixely_d;
      gano_q   <= gano_d;
      frame_q  <= frame_d;
      tog_q    <= tog_d;
      vb_q     <= vb;
    end
  end

  always_comb begin
    state_d  = state_q;
    pixely_d = pixely_q;
    gano_d   = gano_q;
    frame_d  = frame_q;
    tog_d    = tog_q;
    if (clear) begin
      state_d  = ST_IDLE;
      pixely_d = SY_10;
      gano_d   = 1'b0;
      frame_d  = '0;
      tog_d    = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          gano_d   = 1'b0;
          pixely_d = SY_10;
          if (win) begin
            gano_d = 1'b1;
`ifdef BANNER_SLIDE_EN
            state_d = ST_SLIDE;
`else
            state_d  = ST_BLINK;
            pixely_d = TY_10;
            frame_d  = '0;
            tog_d    = '0;
`endif
          end
        end
        ST_SLIDE: begin
`ifdef BANNER_SLIDE_EN
          gano_d = 1'b1;
          if (tick) begin
            if (slide_sum >= TY_11) begin
              pixely_d = TY_10;
              state_d  = ST_BLINK;
              frame_d  = '0;
              tog_d    = '0;
            end else begin
              pixely_d = slide_sum[9:0];
            end
          end
`else
          state_d = ST_IDLE;
`endif
        end
        ST_BLINK: begin
          if (tick) begin
            if (frame_q == FC_LAST) begin
              frame_d = '0;
              gano_d  = ~gano_q;
              tog_d   = tog_q + 1'b1;
              // Last toggle of an even count always lands on visible.
              if (tog_q == TG_LAST) begin
                state_d = ST_HOLD;
                gano_d  = 1'b1;
              end
            end else begin
              frame_d = frame_q + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          gano_d   = 1'b1;
          pixely_d = TY_10;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign pixelx = TX_10;
  assign pixely = pixely_q;
  assign gano   = gano_q;
  assign state  = state_q;

endmodule

// File: tb/tb_ganador_banner_ctrl.sv
// Randomized bench for ganador_banner_ctrl against a ticks-since-win reference model.
module tb_ganador_banner_ctrl;

  localparam int unsigned TX = 275;
  localparam int unsigned SY = 0;
  localparam int unsigned TY = 232;
  localparam int unsigned STEP = 8;
  localparam int unsigned BF = 15;
  localparam int unsigned BC = 3;
`ifdef BANNER_SLIDE_EN
  localparam bit SLIDE_EN = 1'b1;
`else
  localparam bit SLIDE_EN = 1'b0;
`endif
  localparam int unsigned N_SLIDE     = SLIDE_EN ? (TY - SY + STEP - 1) / STEP : 0;
  localparam int unsigned BLINK_TICKS = 2 * BC * BF;

  logic       clk = 1'b0;
  logic       rst = 1'b1, win = 1'b0, clear = 1'b0;
  logic [9:0] posx = 10'd5, posy = 10'd5;
  logic [9:0] pixelx, pixely;
  logic       gano;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  // Model: banner active since a win, and number of frame ticks seen since then.
  bit          m_active = 1'b0;
  int unsigned m_k = 0;
  bit          m_prev_vb = 1'b0;

  always #5 clk = ~clk;

  ganador_banner_ctrl #(
    .SCREEN_H(480), .SPR_H(16), .TARGET_X(TX), .START_Y(SY), .TARGET_Y(TY),
    .STEP(STEP), .BLINK_FRAMES(BF), .BLINK_COUNT(BC)
  ) dut (
    .clk(clk), .rst(rst), .posx(posx), .posy(posy), .win(win), .clear(clear),
    .pixelx(pixelx), .pixely(pixely), .gano(gano), .state(state)
  );

  function automatic logic [1:0] exp_state();
    if (!m_active) return 2'd0;
    if (m_k < N_SLIDE) return 2'd1;
    if (m_k - N_SLIDE >= BLINK_TICKS) return 2'd3;
    return 2'd2;
  endfunction

  function automatic logic [9:0] exp_y();
    if (!m_active) return 10'(SY);
    if (m_k < N_SLIDE) return 10'(SY + m_k * STEP);
    return 10'(TY);
  endfunction

  function automatic logic exp_g();
    int unsigned b;
    if (!m_active) return 1'b0;
    if (m_k < N_SLIDE) return 1'b1;
    b = m_k - N_SLIDE;
    if (b >= BLINK_TICKS) return 1'b1;
    return ((b / BF) % 2) == 0;
  endfunction

  task automatic cyc(input bit r, input bit w, input bit c, input bit vbl);
    bit tick;
    rst = r; win = w; clear = c;
    if (vbl) begin
      posx = 10'd0; posy = 10'd480;
    end else if ($urandom_range(0, 3) == 0) begin
      posx = 10'($urandom_range(1, 799)); posy = 10'd480;
    end else begin
      posx = 10'($urandom_range(0, 799)); posy = 10'($urandom_range(0, 479));
    end
    @(posedge clk);
    if (r) begin
      m_active = 1'b0; m_k = 0; m_prev_vb = 1'b0;
    end else begin
      tick = vbl && !m_prev_vb;
      m_prev_vb = vbl;
      if (c) m_active = 1'b0;
      else if (!m_active) begin
        if (w) begin m_active = 1'b1; m_k = 0; end
      end else if (tick && m_k < 100000) m_k++;
    end
    #1;
  endtask

  task automatic frame(input bit w_fill);
    int unsigned hold = $urandom_range(1, 5);
    int unsigned fill = $urandom_range(1, 3);
    repeat (hold) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (fill) cyc(1'b0, w_fill, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({state, gano, pixely, pixelx} !== {2'd0, 1'b0, 10'd0, 10'd275}) begin
      errors++;
      $display("FAIL reset: state/gano/pixely/pixelx got %0d/%0d/%0d/%0d want 0/0/0/275",
               state, gano, pixely, pixelx);
    end
    for (int i = 0; i < 6; i++) begin
      frame(1'b0);
      checks++;
      if ({state, gano, pixely, pixelx} !== {exp_state(), exp_g(), exp_y(), 10'(TX)}) begin
        errors++;
        $display("FAIL idle frame %0d: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", i,
                 state, gano, pixely, pixelx, exp_state(), exp_g(), exp_y(), TX);
      end
    end
  endtask

  task automatic test_slide_blink_hold();
    int unsigned frames = 0;
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({state, gano, pixely} !== (SLIDE_EN ? {2'd1, 1'b1, 10'd0} : {2'd2, 1'b1, 10'd232})) begin
      errors++;
      $display("FAIL win start: state/gano/pixely got %0d/%0d/%0d want %0d/1/%0d",
               state, gano, pixely, SLIDE_EN ? 1 : 2, SLIDE_EN ? 0 : 232);
    end
    while (m_k < N_SLIDE + BLINK_TICKS + 200 && frames < 1000) begin
      frame($urandom_range(0, 7) == 0);
      frames++;
      checks++;
      if ({state, gano, pixely, pixelx} !== {exp_state(), exp_g(), exp_y(), 10'(TX)}) begin
        errors++;
        $display("FAIL anim tick %0d: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", m_k,
                 state, gano, pixely, pixelx, exp_state(), exp_g(), exp_y(), TX);
      end
      if (N_SLIDE > 0 && m_k == N_SLIDE) begin
        checks++;
        if (state !== 2'd2 || pixely !== 10'd232) begin
          errors++;
          $display("FAIL slide end: state/pixely got %0d/%0d want 2/232", state, pixely);
        end
      end
      if (m_k == N_SLIDE + BF) begin
        checks++;
        if (gano !== 1'b0) begin
          errors++;
          $display("FAIL first toggle: gano got %0d want 0", gano);
        end
      end
      if (m_k == N_SLIDE + BLINK_TICKS) begin
        checks++;
        if (state !== 2'd3 || gano !== 1'b1) begin
          errors++;
          $display("FAIL hold entry: state/gano got %0d/%0d want 3/1", state, gano);
        end
      end
    end
    if (frames >= 1000) begin
      errors++;
      $display("FAIL anim budget: frames %0d expired", frames);
    end
  endtask

  task automatic test_tick_once();
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if ({state, gano, pixely} !== {exp_state(), exp_g(), exp_y()}) begin
        errors++;
        $display("FAIL held vblank cyc %0d: got %0d/%0d/%0d want %0d/%0d/%0d", i,
                 state, gano, pixely, exp_state(), exp_g(), exp_y());
      end
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (pixely !== (SLIDE_EN ? 10'd8 : 10'd232)) begin
      errors++;
      $display("FAIL single tick: pixely got %0d want %0d", pixely, SLIDE_EN ? 8 : 232);
    end
  endtask

  task automatic test_clear_priority();
    int unsigned frames = 0;
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    while (m_k < N_SLIDE + 5 && frames < 200) begin
      frame(1'b0);
      frames++;
    end
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if ({state, gano, pixely} !== {2'd0, 1'b0, 10'd0}) begin
      errors++;
      $display("FAIL clear+win: state/gano/pixely got %0d/%0d/%0d want 0/0/0", state, gano, pixely);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({state, gano, pixely} !== {2'd0, 1'b0, 10'd0}) begin
      errors++;
      $display("FAIL idle after clear: got %0d/%0d/%0d want 0/0/0", state, gano, pixely);
    end
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({state, gano, pixely} !== (SLIDE_EN ? {2'd1, 1'b1, 10'd0} : {2'd2, 1'b1, 10'd232})) begin
      errors++;
      $display("FAIL restart: state/gano/pixely got %0d/%0d/%0d want %0d/1/%0d",
               state, gano, pixely, SLIDE_EN ? 1 : 2, SLIDE_EN ? 0 : 232);
    end
    frame(1'b0);
    checks++;
    if (pixely !== exp_y() || gano !== exp_g()) begin
      errors++;
      $display("FAIL restart frame: pixely/gano got %0d/%0d want %0d/%0d", pixely, gano, exp_y(), exp_g());
    end
    frame(1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({state, gano, pixely} !== {2'd0, 1'b0, 10'd0}) begin
      errors++;
      $display("FAIL reset mid-anim: got %0d/%0d/%0d want 0/0/0", state, gano, pixely);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      int unsigned r = $urandom_range(0, 99);
      if (r < 2) cyc(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      else if (r < 6) cyc(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)));
      else if (r < 14) cyc(1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)));
      else frame($urandom_range(0, 9) == 0);
      checks++;
      if ({state, gano, pixely, pixelx} !== {exp_state(), exp_g(), exp_y(), 10'(TX)}) begin
        errors++;
        $display("FAIL random step %0d: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", i,
                 state, gano, pixely, pixelx, exp_state(), exp_g(), exp_y(), TX);
      end
    end
  endtask

  initial begin
    test_reset();
    test_slide_blink_hold();
    test_tick_once();
    test_clear_priority();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ganador_banner_ctrl.md
Name: ganador_banner_ctrl

Overview:
Upstream animation controller for the winner ("Ganador") banner sprite stage.
- On a win from game logic: drives the banner top-left (pixelx, pixely) so it slides down from the top of the screen to a centred target, blinks a fixed number of times, then holds steady until the next game.
- Outputs feed the sprite positioning stage directly: pixelx/pixely as sprite origin, gano as its enable.
- Position and enable change only on a once-per-frame vblank tick derived from the scan counters, so the banner never tears mid-frame.

Parameters:
SCREEN_H, 480, visible lines; vblank tick fires when posy first equals SCREEN_H
SPR_H, 16, banner height; TARGET_Y+SPR_H must not exceed SCREEN_H
TARGET_X, 275, fixed banner x origin (centred 90-px banner)
START_Y, 0, pixely value in IDLE and at slide start
TARGET_Y, 232, final pixely
STEP, 8, pixels moved per frame during slide (1..63)
BLINK_FRAMES, 15, frames per blink half-period (>=1)
BLINK_COUNT, 3, number of full on/off blink cycles

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
posx  in  10  current scan x from VGA timing
posy  in  10  current scan y from VGA timing
win  in  1  level/pulse from game logic: winner detected
clear  in  1  new game / board reset
pixelx  out  10  banner origin x
pixely  out  10  banner origin y
gano  out  1  banner enable to sprite stage
state  out  2  IDLE=0, SLIDE=1, BLINK=2, HOLD=3 (debug)

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, pixelx=TARGET_X, pixely=START_Y, gano=0.
  - Frame counter, toggle counter and tick-detect register cleared.
- Frame tick:
  - vb = (posx==0 && posy==SCREEN_H); vb_q registered every cycle.
  - tick = vb & ~vb_q; exactly one cycle per frame, even if posx/posy hold for several clk cycles.
  - All outputs are registered; they change on the cycle after the event that causes them.
- IDLE:
  - gano=0, pixely=START_Y.
  - win=1 -> SLIDE next cycle with gano=1. No tick needed to leave IDLE.
- SLIDE, on each tick:
  - Compute sum = pixely+STEP in 11 bits (no wrap).
  - If sum >= TARGET_Y: pixely=TARGET_Y, state=BLINK, frame_cnt=0, toggles=0.
  - Otherwise pixely=sum.
  - gano stays 1.
- BLINK, on each tick:
  - frame_cnt increments.
  - When frame_cnt==BLINK_FRAMES-1: frame_cnt=0, gano toggles, toggles increments.
  - When toggles reaches 2*BLINK_COUNT: state=HOLD, gano=1 (the final toggle leaves gano=1).
- HOLD:
  - gano=1, pixely=TARGET_Y, until clear.
- clear=1 in any state: IDLE next cycle, same values as reset. clear has priority over win in the same cycle.
- win outside IDLE is ignored; a retriggered win does not restart the animation.
- Between ticks all state, counters and outputs are stable.
- pixelx is constant TARGET_X in all states.
- rst or clear mid-SLIDE or mid-BLINK: banner disappears on the next cycle (gano=0).

Optional Feature:
BANNER_SLIDE_EN
- Defined: behaviour as above.
- Undefined:
  - SLIDE is never entered; win in IDLE goes directly to BLINK with pixely=TARGET_Y and gano=1.
  - State encoding is unchanged; state never reads 1.

Test Plan:
- Reset, then idle frames with win=0 -> gano=0, pixely=0, pixelx=275, state=0 throughout.
- Pulse win for 1 cycle, then drive frames -> next cycle state=1, gano=1; pixely 8,16,...,224 on ticks 1-28, 232 on tick 29 with state=2.
- Continue frames after tick 29 -> gano toggles to 0 after 15 ticks, 1 after 30 ticks, ..., 6 toggles at tick 90 post-slide; state=3 with gano=1, stable for 200 further frames.
- Hold posx=0, posy=480 for 5 clk cycles -> exactly one tick; pixely advances by 8 only once.
- Assert clear and win in the same cycle mid-BLINK -> state=0, gano=0, pixely=0 next cycle. A win 3 cycles later restarts the slide from pixely=0.
- BANNER_SLIDE_EN undefined, win pulse -> state=2, pixely=232, gano=1 next cycle; first toggle to gano=0 at tick 15.
